// File: rtl/ballot_box_if.sv
`timescale 1ns/1ps
// Ballot-box handshake bundle: ballot input, close pulse, result output with ack.
interface ballot_box_if #(
    parameter int N = 2,
    parameter int M = 2
);
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] voter_id;
    logic [N-1:0] choice;
    logic         close;
    logic         out_valid;
    logic         out_ack;
    logic [N-1:0] winner;
    logic [M:0]   win_count;
    logic         dup_err;

    modport master (
        output in_valid, voter_id, choice, close, out_ack,
        input  in_ready, out_valid, winner, win_count, dup_err
    );

    modport slave (
        input  in_valid, voter_id, choice, close, out_ack,
        output in_ready, out_valid, winner, win_count, dup_err
    );
endinterface

// File: rtl/ballot_box.sv
`timescale 1ns/1ps
// ballot_box: saturating per-candidate tallies, then a one-candidate-per-cycle max scan.
// Define BALLOT_DUP_CHECK_EN to drop repeat ballots from the same voter (dup_err pulse).

module ballot_tally #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end
endmodule

module ballot_box #(
    parameter int N = 2,
    parameter int M = 2
) (
    input  logic        clk,
    input  logic        rst,
    ballot_box_if.slave bus
);
    localparam int NC = 2 ** N;
    localparam int TW = M + 1;
    // Index runs one past the last candidate: that extra cycle latches the result.
    localparam logic [N:0] SCAN_END = (N + 1)'(NC);

    typedef enum logic [1:0] {COLLECT, SCAN, DONE} state_t;

    state_t                 state, state_nxt;
    logic                   rdy_q;
    logic                   accept;
    logic                   dup;
    logic                   clr;
    logic [NC-1:0]          inc;
    logic [NC-1:0][TW-1:0]  tally;
    logic [N:0]             idx;
    logic [N-1:0]           best_idx;
    logic [TW-1:0]          best_cnt;

    // rdy_q keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdy_q <= 1'b0;
        else      rdy_q <= 1'b1;
    end

    assign bus.in_ready  = rdy_q && (state == COLLECT);
    assign bus.out_valid = (state == DONE);
    assign accept        = bus.in_valid && bus.in_ready;
    assign clr           = (state == DONE) && bus.out_ack;

`ifdef BALLOT_DUP_CHECK_EN
    logic [2**M-1:0] voted;

    assign dup = voted[bus.voter_id];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            voted       <= '0;
            bus.dup_err <= 1'b0;
        end else begin
            bus.dup_err <= accept && dup;
            if (clr)
                voted <= '0;
            else if (accept && !dup)
                voted[bus.voter_id] <= 1'b1;
        end
    end
`else
    logic unused_voter_id;

    assign unused_voter_id = ^bus.voter_id;
    assign dup             = 1'b0;
    assign bus.dup_err     = 1'b0;
`endif

    for (genvar i = 0; i < NC; i++) begin : g_tally
        assign inc[i] = accept && !dup && (bus.choice == N'(i));
        ballot_tally #(.W(TW)) u_tally (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .inc (inc[i]),
            .cnt (tally[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= COLLECT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (bus.close)       state_nxt = SCAN;
            SCAN:    if (idx == SCAN_END) state_nxt = DONE;
            DONE:    if (bus.out_ack)     state_nxt = COLLECT;
            default:                      state_nxt = COLLECT;
        endcase
    end

    // Strict greater-than keeps the lowest index on ties; all-zero leaves 0/0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx           <= '0;
            best_idx      <= '0;
            best_cnt      <= '0;
            bus.winner    <= '0;
            bus.win_count <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (bus.close) begin
                        idx      <= '0;
                        best_idx <= '0;
                        best_cnt <= '0;
                    end
                end
                SCAN: begin
                    if (idx != SCAN_END) begin
                        if (tally[idx[N-1:0]] > best_cnt) begin
                            best_idx <= idx[N-1:0];
                            best_cnt <= tally[idx[N-1:0]];
                        end
                        idx <= idx + 1'b1;
                    end else begin
                        bus.winner    <= best_idx;
                        bus.win_count <= best_cnt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ballot_box.sv
`timescale 1ns/1ps
// Self-checking bench for ballot_box: directed table, reset corner and random elections vs a tally model.
module tb_ballot_box;
    localparam int N    = 2;
    localparam int M    = 2;
    localparam int NC   = 1 << N;
    localparam int NV   = 1 << M;
    localparam int TMAX = (1 << (M + 1)) - 1;
    localparam int LAT  = NC + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ballot_box_if #(.N(N), .M(M)) bus ();
    ballot_box #(.N(N), .M(M)) dut (.clk(clk), .rst(rst), .bus(bus));

    int nvec = 0;
    int nerr = 0;
    int obs_dups = 0;

    int m_tally[NC];
    bit m_voted[NV];
    int m_dups;

    typedef struct {
        string name;
        int    n;
        int    vid[10];
        int    ch[10];
        bit    cb;
        int    cb_vid;
        int    cb_ch;
        int    w;
        int    c;
        int    d;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void m_clear();
        for (int i = 0; i < NC; i++) m_tally[i] = 0;
        for (int i = 0; i < NV; i++) m_voted[i] = 1'b0;
        m_dups = 0;
    endfunction

    function automatic void m_cast(input int vid, input int ch);
`ifdef BALLOT_DUP_CHECK_EN
        if (m_voted[vid]) begin
            m_dups++;
            return;
        end
        m_voted[vid] = 1'b1;
`endif
        if (m_tally[ch] < TMAX) m_tally[ch]++;
    endfunction

    // Winner = first index holding the maximum tally.
    task automatic m_result(output int w, output int c);
        int mx = 0;
        foreach (m_tally[i]) if (m_tally[i] > mx) mx = m_tally[i];
        w = 0;
        for (int i = NC - 1; i >= 0; i--) if (m_tally[i] == mx) w = i;
        c = mx;
    endtask

    task automatic cast(input int vid, input int ch, input bit ack_noise);
        bus.in_valid = 1'b1;
        bus.voter_id = M'(vid);
        bus.choice   = N'(ch);
        bus.out_ack  = ack_noise;
        tick();
        if (bus.dup_err) obs_dups++;
        bus.in_valid = 1'b0;
        bus.out_ack  = 1'b0;
        m_cast(vid, ch);
    endtask

    task automatic elect(input string name, input bit cb, input int cb_vid, input int cb_ch,
                         input bit noise, input int w, input int c, input int d);
        int lat = 0;
        bus.close = 1'b1;
        if (cb) begin
            bus.in_valid = 1'b1;
            bus.voter_id = M'(cb_vid);
            bus.choice   = N'(cb_ch);
        end
        tick();
        if (bus.dup_err) obs_dups++;
        bus.close    = 1'b0;
        bus.in_valid = 1'b0;
        chk({name, "_ready_scan"}, bus.in_ready, 0);
        while (!bus.out_valid && lat < 20) begin
            if (noise) begin
                bus.in_valid = 1'b1;
                bus.voter_id = M'($urandom_range(0, NV - 1));
                bus.choice   = N'($urandom_range(0, NC - 1));
                bus.close    = 1'($urandom_range(0, 1));
            end
            tick();
            if (bus.dup_err) obs_dups++;
            lat++;
        end
        bus.in_valid = 1'b0;
        bus.close    = 1'b0;
        chk({name, "_latency"}, lat, LAT);
        chk({name, "_winner"}, bus.winner, w);
        chk({name, "_count"}, bus.win_count, c);
        chk({name, "_dups"}, obs_dups, d);
        tick();
        tick();
        chk({name, "_hold"}, {bus.out_valid, bus.in_ready, bus.winner, bus.win_count},
            {1'b1, 1'b0, N'(w), (M + 1)'(c)});
        bus.out_ack = 1'b1;
        tick();
        bus.out_ack = 1'b0;
        chk({name, "_ack"}, {bus.out_valid, bus.in_ready}, 2'b01);
        m_clear();
        obs_dups = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, c, n, vid, ch;
        bit cb;

        tbl[0] = '{"vote_2123", 4, '{0,1,2,3,0,0,0,0,0,0}, '{2,1,2,3,0,0,0,0,0,0}, 1'b0, 0, 0, 2, 2, 0};
        tbl[1] = '{"tie_3131",  4, '{0,1,2,3,0,0,0,0,0,0}, '{3,1,3,1,0,0,0,0,0,0}, 1'b0, 0, 0, 1, 2, 0};
        tbl[2] = '{"empty",     0, '{0,0,0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,0,0}, 1'b0, 0, 0, 0, 0, 0};
        tbl[4] = '{"close_bal", 0, '{0,0,0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,0,0}, 1'b1, 0, 3, 3, 1, 0};
`ifdef BALLOT_DUP_CHECK_EN
        tbl[3] = '{"dup",       3, '{1,1,2,0,0,0,0,0,0,0}, '{0,2,2,0,0,0,0,0,0,0}, 1'b0, 0, 0, 0, 1, 1};
        tbl[5] = '{"saturate",  9, '{0,1,2,3,0,1,2,3,0,0}, '{1,1,1,1,1,1,1,1,1,0}, 1'b0, 0, 0, 1, 4, 5};
`else
        tbl[3] = '{"dup",       3, '{1,1,2,0,0,0,0,0,0,0}, '{0,2,2,0,0,0,0,0,0,0}, 1'b0, 0, 0, 2, 2, 0};
        tbl[5] = '{"saturate",  9, '{0,1,2,3,0,1,2,3,0,0}, '{1,1,1,1,1,1,1,1,1,0}, 1'b0, 0, 0, 1, 7, 0};
`endif

        bus.in_valid = 1'b0;
        bus.voter_id = '0;
        bus.choice   = '0;
        bus.close    = 1'b0;
        bus.out_ack  = 1'b0;
        m_clear();

        #12;
        chk("reset_outputs", {bus.in_ready, bus.out_valid, bus.winner, bus.win_count, bus.dup_err}, '0);
        rst = 1'b1;
        tick();
        chk("ready_after_release", bus.in_ready, 1);

        foreach (tbl[k]) begin
            for (int i = 0; i < tbl[k].n; i++) cast(tbl[k].vid[i], tbl[k].ch[i], 1'b0);
            if (tbl[k].cb) m_cast(tbl[k].cb_vid, tbl[k].cb_ch);
            elect(tbl[k].name, tbl[k].cb, tbl[k].cb_vid, tbl[k].cb_ch, tbl[k].cb,
                  tbl[k].w, tbl[k].c, tbl[k].d);
        end

        // Reset mid-scan abandons the election.
        cast(0, 1, 1'b0);
        cast(1, 1, 1'b0);
        bus.close = 1'b1;
        tick();
        bus.close = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1;
        chk("rst_scan_outputs", {bus.in_ready, bus.out_valid, bus.winner, bus.win_count}, '0);
        tick();
        #2 rst = 1'b1;
        tick();
        chk("rst_scan_ready", bus.in_ready, 1);
        for (int i = 0; i < 8; i++) tick();
        chk("rst_scan_no_result", bus.out_valid, 0);
        m_clear();
        obs_dups = 0;
        elect("post_rst_empty", 1'b0, 0, 0, 1'b0, 0, 0, 0);
        cast(3, 2, 1'b0);
        elect("post_rst_one", 1'b0, 0, 0, 1'b0, 2, 1, 0);

        for (int e = 0; e < 30; e++) begin
            n = $urandom_range(0, 10);
            for (int i = 0; i < n; i++)
                cast($urandom_range(0, NV - 1), $urandom_range(0, NC - 1), 1'($urandom_range(0, 1)));
            cb  = 1'($urandom_range(0, 1));
            vid = $urandom_range(0, NV - 1);
            ch  = $urandom_range(0, NC - 1);
            if (cb) m_cast(vid, ch);
            m_result(w, c);
            elect($sformatf("rand%0d", e), cb, vid, ch, 1'b1, w, c, m_dups);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/ballot_box.md
BALLOT_BOX -- requirements
Module: ballot_box

Interface
REQ-001 SHALL have parameter N, default 2: candidate-index width; 2**N candidates.
REQ-002 SHALL have parameter M, default 2: voter-ID width; 2**M voters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low; logic 0 resets the block.
REQ-005 SHALL have port in_valid  input  1  ballot present on voter_id/choice.
REQ-006 SHALL have port in_ready  output  1  block can accept a ballot this cycle.
REQ-007 SHALL have port voter_id  input  M  ID of the voter casting the ballot.
REQ-008 SHALL have port choice  input  N  index of the chosen candidate.
REQ-009 SHALL have port close  input  1  single-cycle pulse that ends collection.
REQ-010 SHALL have port out_valid  output  1  result valid on winner/win_count.
REQ-011 SHALL have port out_ack  input  1  result consumed; start a new election.
REQ-012 SHALL have port winner  output  N  index of the winning candidate.
REQ-013 SHALL have port win_count  output  M+1  tally of the winning candidate.
REQ-014 SHALL have port dup_err  output  1  one-cycle pulse when a duplicate ballot is dropped.

Function
REQ-015 SHALL use three states: COLLECT, SCAN and DONE.
REQ-016 SHALL leave reset in COLLECT with all tallies 0.
REQ-017 SHALL drive in_ready=1 only in COLLECT.
REQ-018 SHALL accept a ballot on the cycle where in_valid and in_ready are both 1; acceptance increments tally[choice] by 1 on that edge.
REQ-019 SHALL keep each tally M+1 bits wide, saturating at 2**(M+1)-1 and never wrapping.
REQ-020 SHALL, on close=1 in COLLECT, move to SCAN on the next edge; a ballot accepted in that same cycle is counted before the scan.
REQ-021 SHALL ignore close in SCAN and DONE.
REQ-022 SHALL have SCAN compare one candidate per cycle, index 0 first, for exactly 2**N cycles, then enter DONE.
REQ-023 SHALL replace the best candidate only on strict greater-than, so ties go to the lowest index.
REQ-024 SHALL report winner=0 and win_count=0 when all tallies are 0.
REQ-025 SHALL assert out_valid exactly in DONE, with winner/win_count held stable for the whole of DONE.
REQ-026 SHALL raise out_valid 2**N+1 cycles after the close edge.
REQ-027 SHALL, on out_ack=1 in DONE, clear all tallies and the voted flags, deassert out_valid and return to COLLECT on the next edge.
REQ-028 SHALL ignore out_ack outside DONE.
REQ-029 SHALL ignore in_valid outside COLLECT: nothing is counted and no error is raised.

Reset
REQ-030 SHALL, while rst=0, asynchronously force state=COLLECT, tallies=0, voted flags=0, the scan index and best registers=0, out_valid=0, winner=0, win_count=0 and dup_err=0.
REQ-031 SHALL, on reset asserted mid-SCAN or in DONE, abandon the election; no result is produced.
REQ-032 SHALL force in_ready=0 while rst=0 and take in_ready=1 at the first clock edge after release.

Configuration
REQ-033 SHALL use macro BALLOT_DUP_CHECK_EN to compile duplicate-ballot rejection in or out.
REQ-034 SHALL, with BALLOT_DUP_CHECK_EN defined, keep a 2**M-bit voted flag vector; an accepted ballot from a voter whose flag is already set is dropped (no tally change) and pulses dup_err for one cycle; otherwise the tally is incremented and the flag is set.
REQ-035 SHALL, with BALLOT_DUP_CHECK_EN undefined, omit the voted flags, count every accepted ballot and tie dup_err to 0.

Verification (N=2, M=2)
REQ-036 SHALL cover: voters 0..3 vote 2,1,2,3, then close -> out_valid 5 cycles after close, winner=2, win_count=2.
REQ-037 SHALL cover: votes 3,1,3,1, then close -> winner=1, win_count=2 (lowest-index tie-break).
REQ-038 SHALL cover: close with no ballots -> winner=0, win_count=0.
REQ-039 SHALL cover, with the macro defined: voter 1 votes 0 then 2, voter 2 votes 2, then close -> second ballot dropped, dup_err pulses once, winner=0 (tally 0:1, 2:1), win_count=1.
REQ-040 SHALL cover: a ballot for candidate 3 together with close in the same cycle (other tallies 0) -> counted, winner=3, win_count=1; in_valid in SCAN is ignored.
REQ-041 SHALL cover: rst=0 during SCAN -> out_valid stays 0 and all tallies read 0; a new election after release counts from zero.
